// File: rtl/freq_lock_regulator.sv
// freq_lock_regulator
// Measures the high time of psi in clk cycles, compares it with set_period and
// steps a divider value once per pulse. adjust_div carries the inverted divider
// value to the downstream programmable divider. locked rises after LOCK_COUNT
// consecutive in-band pulses.
//
// Handshake: meas_valid is a one-cycle, ready-less strobe. It is high only in
// the UPDATE cycle while en=1. duration is valid whenever meas_valid is high.
// inc/dec/locked/adjust_div take their new values on the edge that ends that
// cycle.
module freq_lock_regulator #(
   parameter int CNT_W       = 8,
   parameter int DIV_W       = 8,
   parameter int DIV_INIT    = 1,
   parameter int DIV_MIN     = 1,
   parameter int DIV_MAX     = 255,
   parameter int DEADBAND    = 0,
   parameter int COARSE_THR  = 8,
   parameter int COARSE_STEP = 4,
   parameter int LOCK_COUNT  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             psi,
   input  logic [CNT_W-1:0] set_period,
   output logic [DIV_W-1:0] adjust_div,
   output logic [CNT_W-1:0] duration,
   output logic             meas_valid,
   output logic             inc,
   output logic             dec,
   output logic             locked,
   output logic [1:0]       dbg_state
);

   localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

   localparam logic [CNT_W-1:0]        CNT_SAT  = '1;
   localparam logic signed [CNT_W:0]   DB_POS   = (CNT_W+1)'(DEADBAND);
   localparam logic signed [CNT_W:0]   DB_NEG   = -DB_POS;
   localparam logic [CNT_W:0]          THR      = (CNT_W+1)'(COARSE_THR);
   localparam logic [DIV_W:0]          STEP_C   = (DIV_W+1)'(COARSE_STEP);
   localparam logic [DIV_W:0]          STEP_F   = (DIV_W+1)'(1);
   localparam logic [DIV_W:0]          MAX_X    = (DIV_W+1)'(DIV_MAX);
   localparam logic [DIV_W:0]          MIN_X    = (DIV_W+1)'(DIV_MIN);
   localparam logic [DIV_W-1:0]        INIT_DIV = DIV_W'(DIV_INIT);
   localparam logic [LOCK_W-1:0]       LOCK_N   = LOCK_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_WAIT_LOW = 2'd0,
      S_IDLE     = 2'd1,
      S_MEASURE  = 2'd2,
      S_UPDATE   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_psi_q;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_duration;
   logic [DIV_W-1:0]    r_div;
   logic                r_inc;
   logic                r_dec;
   logic                r_locked;
   logic [LOCK_W-1:0]   r_lock_cnt;

   logic                w_rise;
   logic                w_cnt_load;
   logic                w_cnt_step;
   logic                w_capture;
   logic                w_update;
   logic signed [CNT_W:0] w_err;
   logic [CNT_W:0]      w_abs;
   logic                w_too_long;
   logic                w_too_short;
   logic [DIV_W:0]      w_step;
   logic [DIV_W:0]      w_div_x;
   logic [DIV_W:0]      w_up;
   logic [DIV_W-1:0]    w_div_inc;
   logic [DIV_W-1:0]    w_div_dec;

   assign w_rise = psi & ~r_psi_q;

   // Error is duration minus target, one bit wider so it never wraps.
   assign w_err       = $signed({1'b0, r_duration}) - $signed({1'b0, set_period});
   assign w_abs       = w_err[CNT_W] ? $unsigned(-w_err) : $unsigned(w_err);
   assign w_too_long  = w_err > DB_POS;
   assign w_too_short = w_err < DB_NEG;
   assign w_step      = (w_abs > THR) ? STEP_C : STEP_F;

   // Divider stepping is done one bit wider and clamped, so it never wraps.
   assign w_div_x   = {1'b0, r_div};
   assign w_up      = w_div_x + w_step;
   assign w_div_inc = (w_up > MAX_X) ? MAX_X[DIV_W-1:0] : w_up[DIV_W-1:0];
   assign w_div_dec = (w_div_x < MIN_X + w_step) ? MIN_X[DIV_W-1:0]
                                                 : r_div - w_step[DIV_W-1:0];

   assign adjust_div = ~r_div;
   assign duration   = r_duration;
   assign meas_valid = w_update;
   assign inc        = r_inc;
   assign dec        = r_dec;
   assign locked     = r_locked;
   assign dbg_state  = r_state;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_WAIT_LOW;
      else     r_state <= w_next;
   end

   // Next-state and per-cycle control strobes; en=0 forces a restart from WAIT_LOW.
   always_comb begin
      w_next     = r_state;
      w_cnt_load = 1'b0;
      w_cnt_step = 1'b0;
      w_capture  = 1'b0;
      w_update   = 1'b0;
      if (!en) begin
         w_next = S_WAIT_LOW;
      end else begin
         case (r_state)
            S_WAIT_LOW: if (!psi) w_next = S_IDLE;
            S_IDLE: begin
               if (w_rise) begin
                  w_next     = S_MEASURE;
                  w_cnt_load = 1'b1;
               end
            end
            // psi_q is always 1 here, so psi low is exactly the falling edge.
            S_MEASURE: begin
               if (psi) begin
                  w_cnt_step = 1'b1;
               end else begin
                  w_capture = 1'b1;
                  w_next    = S_UPDATE;
               end
            end
            S_UPDATE: begin
               w_update = 1'b1;
               if (w_rise) begin
                  w_next     = S_MEASURE;
                  w_cnt_load = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
            default: w_next = S_WAIT_LOW;
         endcase
      end
   end

   // One-cycle delayed copy of psi for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_psi_q <= 1'b0;
      else     r_psi_q <= psi;
   end

   // High-time counter (saturating) and capture of the finished measurement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_duration <= '0;
      end else if (!en) begin
         r_cnt <= '0;
      end else begin
         if (w_cnt_load)                          r_cnt <= CNT_SAT - CNT_SAT + 1'b1;
         else if (w_cnt_step && r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
         if (w_capture) r_duration <= r_cnt;
      end
   end

   // Divider stepping, direction flags and lock tracking, once per measurement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div      <= INIT_DIV;
         r_inc      <= 1'b0;
         r_dec      <= 1'b0;
         r_locked   <= 1'b0;
         r_lock_cnt <= '0;
      end else if (!en) begin
         r_locked   <= 1'b0;
         r_lock_cnt <= '0;
      end else if (w_update) begin
         r_inc <= w_too_short;
         r_dec <= w_too_long;
         if (w_too_short)     r_div <= w_div_inc;
         else if (w_too_long) r_div <= w_div_dec;
         if (w_too_short || w_too_long) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
         end else begin
            if (r_lock_cnt != LOCK_N) r_lock_cnt <= r_lock_cnt + 1'b1;
            r_locked <= (r_lock_cnt >= LOCK_N - 1'b1);
         end
      end
   end

endmodule

// File: tb/tb_freq_lock_regulator.sv
// Bench for freq_lock_regulator: three instances with different parameter sets
// share one stimulus stream and are compared against a pulse-level model.
module tb_freq_lock_regulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       psi;
   logic [7:0] set_period;

   logic [7:0] adj [3];
   logic [7:0] dur [3];
   logic       mv  [3];
   logic       inc [3];
   logic       dec [3];
   logic       lck [3];
   logic [1:0] st  [3];

   int total = 0;
   int bad   = 0;

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got=running exp=finished");
      $fatal(1, "watchdog");
   end

   freq_lock_regulator u_a (
      .clk(clk), .rst(rst), .en(en), .psi(psi), .set_period(set_period),
      .adjust_div(adj[0]), .duration(dur[0]), .meas_valid(mv[0]),
      .inc(inc[0]), .dec(dec[0]), .locked(lck[0]), .dbg_state(st[0]));

   freq_lock_regulator #(.DIV_INIT(20), .DEADBAND(1)) u_b (
      .clk(clk), .rst(rst), .en(en), .psi(psi), .set_period(set_period),
      .adjust_div(adj[1]), .duration(dur[1]), .meas_valid(mv[1]),
      .inc(inc[1]), .dec(dec[1]), .locked(lck[1]), .dbg_state(st[1]));

   freq_lock_regulator #(.DIV_INIT(254)) u_c (
      .clk(clk), .rst(rst), .en(en), .psi(psi), .set_period(set_period),
      .adjust_div(adj[2]), .duration(dur[2]), .meas_valid(mv[2]),
      .inc(inc[2]), .dec(dec[2]), .locked(lck[2]), .dbg_state(st[2]));

   // Reference model: one step per measured pulse, plain integer arithmetic.
   int p_init [3] = '{1, 20, 254};
   int p_db   [3] = '{0, 1, 0};
   int m_div  [3];
   int m_lock [3];
   bit m_locked [3];
   bit m_inc  [3];
   bit m_dec  [3];
   int m_dur;

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_div[k] = p_init[k]; m_lock[k] = 0; m_locked[k] = 0;
         m_inc[k] = 0; m_dec[k] = 0;
      end
      m_dur = 0;
   endfunction

   function automatic void model_disable();
      for (int k = 0; k < 3; k++) begin
         m_lock[k] = 0; m_locked[k] = 0;
      end
   endfunction

   function automatic void model_update(int len, int sp);
      int err, step, mag;
      m_dur = (len > 255) ? 255 : len;
      for (int k = 0; k < 3; k++) begin
         err = m_dur - sp;
         mag = (err < 0) ? -err : err;
         step = (mag > 8) ? 4 : 1;
         m_dec[k] = (err > p_db[k]);
         m_inc[k] = (err < -p_db[k]);
         if (m_inc[k]) m_div[k] = (m_div[k] + step > 255) ? 255 : m_div[k] + step;
         if (m_dec[k]) m_div[k] = (m_div[k] - step < 1) ? 1 : m_div[k] - step;
         if (m_inc[k] || m_dec[k]) begin
            m_lock[k] = 0; m_locked[k] = 0;
         end else begin
            if (m_lock[k] < 4) m_lock[k]++;
            m_locked[k] = (m_lock[k] == 4);
         end
      end
   endfunction

   // Driver tasks: everything is driven and sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds psi high for n sampling edges, then low; returns in the UPDATE cycle.
   task automatic hold_then_fall(input int n);
      psi = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      psi = 1'b0;
      tick();
   endtask

   task automatic apply_reset();
      psi = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      model_reset();
      tick(); tick();
   endtask

   task automatic test_reset();
      logic [27:0] obs, exp;
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         obs = {adj[k], dur[k], mv[k], inc[k], dec[k], lck[k]};
         exp = {~8'(p_init[k]), 8'h00, 4'b0000};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL reset_active[%0d] got=%h exp=%h", k, obs, exp);
         end
      end
      rst = 1'b0;
      model_reset();
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         obs = {adj[k], dur[k], mv[k], inc[k], dec[k], lck[k]};
         exp = {~8'(p_init[k]), 8'h00, 4'b0000};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL reset_release[%0d] got=%h exp=%h", k, obs, exp);
         end
      end
      en = 1'b1;
      tick(); tick();
   endtask

   task automatic test_basic();
      logic [7:0] exp_adj [3] = '{8'hFE, 8'hEC, 8'h02};
      set_period = 8'd10;
      hold_then_fall(12);
      model_update(12, 10);
      total++;
      if (mv[0] !== 1'b1 || dur[0] !== 8'd12 || adj[0] !== 8'hFE) begin
         bad++; $display("FAIL basic_meas got=mv%b dur%0d adj%h exp=mv1 dur12 adjfe", mv[0], dur[0], adj[0]);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         total++;
         if (adj[k] !== exp_adj[k] || dec[k] !== 1'b1 || inc[k] !== 1'b0 || mv[k] !== 1'b0) begin
            bad++; $display("FAIL basic_step[%0d] got=adj%h dec%b inc%b mv%b exp=adj%h dec1 inc0 mv0",
                            k, adj[k], dec[k], inc[k], mv[k], exp_adj[k]);
         end
      end
   endtask

   task automatic test_coarse_fine();
      int         lens  [3] = '{25, 12, 7};
      logic [7:0] exp_b [3] = '{8'd16, 8'd15, 8'd16};
      logic [7:0] exp_a [3] = '{8'd1, 8'd1, 8'd2};
      apply_reset();
      set_period = 8'd10;
      for (int i = 0; i < 3; i++) begin
         hold_then_fall(lens[i]);
         model_update(lens[i], 10);
         tick();
         total++;
         if (adj[1] !== ~exp_b[i] || adj[0] !== ~exp_a[i] || inc[1] !== (i == 2)) begin
            bad++; $display("FAIL coarse_fine[%0d] got=b%h a%h inc%b exp=b%h a%h", i, adj[1], adj[0], inc[1],
                            ~exp_b[i], ~exp_a[i]);
         end
      end
   endtask

   task automatic test_lock();
      int lens    [5] = '{11, 9, 10, 10, 14};
      bit exp_lck [5] = '{0, 0, 0, 1, 0};
      bit exp_dec [5] = '{0, 0, 0, 0, 1};
      int exp_div [5] = '{20, 20, 20, 20, 19};
      apply_reset();
      set_period = 8'd10;
      for (int i = 0; i < 5; i++) begin
         hold_then_fall(lens[i]);
         model_update(lens[i], 10);
         tick();
         total++;
         if (lck[1] !== exp_lck[i] || dec[1] !== exp_dec[i] || inc[1] !== 1'b0 || adj[1] !== ~8'(exp_div[i])) begin
            bad++; $display("FAIL lock[%0d] got=lck%b dec%b inc%b adj%h exp=lck%b dec%b inc0 adj%h", i,
                            lck[1], dec[1], inc[1], adj[1], exp_lck[i], exp_dec[i], ~8'(exp_div[i]));
         end
      end
   endtask

   task automatic test_saturate();
      apply_reset();
      set_period = 8'd200;
      hold_then_fall(5);
      model_update(5, 200);
      tick();
      total++;
      if (adj[2] !== 8'h00 || inc[2] !== 1'b1) begin
         bad++; $display("FAIL sat_max got=adj%h inc%b exp=adj00 inc1", adj[2], inc[2]);
      end
      hold_then_fall(300);
      total++;
      if (mv[2] !== 1'b1 || dur[2] !== 8'd255) begin
         bad++; $display("FAIL sat_dur got=mv%b dur%0d exp=mv1 dur255", mv[2], dur[2]);
      end
      model_update(300, 200);
      tick();
      total++;
      if (dec[2] !== 1'b1 || adj[2] !== 8'h04) begin
         bad++; $display("FAIL sat_dec got=dec%b adj%h exp=dec1 adj04", dec[2], adj[2]);
      end
   endtask

   task automatic test_back_to_back();
      int nmv = 0;
      logic [11:0] obs, exp;
      psi = 1'b1;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      model_reset();
      set_period = 8'd10;
      repeat (6) begin tick(); if (mv[0]) nmv++; end
      psi = 1'b0;
      repeat (3) begin tick(); if (mv[0]) nmv++; end
      total++;
      if (nmv !== 0 || dur[0] !== 8'd0) begin
         bad++; $display("FAIL partial_pulse got=mv_count%0d dur%0d exp=mv_count0 dur0", nmv, dur[0]);
      end
      hold_then_fall(6);
      total++;
      if (mv[0] !== 1'b1 || dur[0] !== 8'd6) begin
         bad++; $display("FAIL b2b_first got=mv%b dur%0d exp=mv1 dur6", mv[0], dur[0]);
      end
      model_update(6, 10);
      psi = 1'b1;
      tick();
      hold_then_fall(8);
      total++;
      if (mv[0] !== 1'b1 || dur[0] !== 8'd9) begin
         bad++; $display("FAIL b2b_second got=mv%b dur%0d exp=mv1 dur9", mv[0], dur[0]);
      end
      model_update(9, 10);
      tick();
      for (int k = 0; k < 3; k++) begin
         obs = {mv[k], adj[k], inc[k], dec[k], lck[k]};
         exp = {1'b0, ~8'(m_div[k]), m_inc[k], m_dec[k], m_locked[k]};
         total++;
         if (obs !== exp) begin
            bad++; $display("FAIL b2b_step[%0d] got=%h exp=%h", k, obs, exp);
         end
      end
   endtask

   task automatic test_abort();
      int nmv = 0;
      logic [26:0] obs, exp;
      set_period = 8'd10;
      for (int i = 0; i < 4; i++) begin
         hold_then_fall(10);
         model_update(10, 10);
         tick();
      end
      total++;
      if (lck[0] !== 1'b1 || lck[1] !== 1'b1 || lck[2] !== 1'b1) begin
         bad++; $display("FAIL abort_prelock got=%b%b%b exp=111", lck[0], lck[1], lck[2]);
      end
      psi = 1'b1;
      repeat (5) begin tick(); if (mv[0]) nmv++; end
      en = 1'b0;
      model_disable();
      repeat (2) begin tick(); if (mv[0]) nmv++; end
      en = 1'b1;
      repeat (3) begin tick(); if (mv[0]) nmv++; end
      psi = 1'b0;
      repeat (3) begin tick(); if (mv[0]) nmv++; end
      for (int k = 0; k < 3; k++) begin
         obs = {adj[k], dur[k], inc[k], dec[k], lck[k]};
         exp = {~8'(m_div[k]), 8'(m_dur), m_inc[k], m_dec[k], m_locked[k]};
         total++;
         if (obs !== exp || nmv !== 0) begin
            bad++; $display("FAIL abort_en[%0d] got=%h mv_count%0d exp=%h mv_count0", k, obs, nmv, exp);
         end
      end
      psi = 1'b1;
      repeat (4) begin tick(); if (mv[0]) nmv++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      repeat (2) begin tick(); if (mv[0]) nmv++; end
      psi = 1'b0;
      repeat (3) begin tick(); if (mv[0]) nmv++; end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (adj[k] !== ~8'(p_init[k]) || dur[k] !== 8'd0 || nmv !== 0) begin
            bad++; $display("FAIL abort_rst[%0d] got=adj%h dur%0d mv_count%0d exp=adj%h dur0 mv_count0",
                            k, adj[k], dur[k], nmv, ~8'(p_init[k]));
         end
      end
   endtask

   task automatic test_random();
      bit          b2b = 0;
      bit          b2b_next;
      int          n, sp, base;
      logic [7:0]  prev [3];
      logic [16:0] obs_u, exp_u;
      logic [11:0] obs_p, exp_p;
      for (int i = 0; i < 150; i++) begin
         n = ($urandom_range(0, 15) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 40);
         if ($urandom_range(0, 1) == 1) begin
            base = ((n > 255) ? 255 : n) + $urandom_range(0, 4) - 2;
            sp = (base < 0) ? 0 : (base > 255) ? 255 : base;
         end else begin
            sp = $urandom_range(0, 255);
         end
         set_period = 8'(sp);
         hold_then_fall(b2b ? n - 1 : n);
         for (int k = 0; k < 3; k++) prev[k] = ~8'(m_div[k]);
         model_update(n, sp);
         for (int k = 0; k < 3; k++) begin
            obs_u = {mv[k], dur[k], adj[k]};
            exp_u = {1'b1, 8'(m_dur), prev[k]};
            total++;
            if (obs_u !== exp_u) begin
               bad++; $display("FAIL rand_meas[%0d.%0d] n=%0d sp=%0d got=%h exp=%h", i, k, n, sp, obs_u, exp_u);
            end
         end
         b2b_next = ($urandom_range(0, 3) == 0);
         if (b2b_next) psi = 1'b1;
         tick();
         for (int k = 0; k < 3; k++) begin
            obs_p = {mv[k], adj[k], inc[k], dec[k], lck[k]};
            exp_p = {1'b0, ~8'(m_div[k]), m_inc[k], m_dec[k], m_locked[k]};
            total++;
            if (obs_p !== exp_p) begin
               bad++; $display("FAIL rand_step[%0d.%0d] n=%0d sp=%0d got=%h exp=%h", i, k, n, sp, obs_p, exp_p);
            end
         end
         b2b = b2b_next;
      end
      psi = 1'b0;
      tick(); tick();
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      psi = 1'b0;
      set_period = 8'd0;
      test_reset();
      test_basic();
      test_coarse_fine();
      test_lock();
      test_saturate();
      test_back_to_back();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
